board_ram: RTL and testbench
============================

Name: board_ram

Overview:
Parametrised single-clock board memory for the puzzle datapath. It replaces full-array reset with a sequential clear/initialise engine, and adds a request/response command port supporting read, write, atomic two-cell swap and clear. A separate combinational read port serves display/scan logic. The game controller issues moves as swap commands.

Parameters:
DATA_W, 8, width of each entry
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
INIT_MODE, 0, clear pattern: 0 = all zero; 1 = entry i gets (i+1) mod DEPTH (solved board, last cell blank); requires DATA_W >= ADDR_W

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  command present
req_ready  out  1  block accepts a command this cycle
req_op  in  2  00 read, 01 write, 10 swap, 11 clear
req_addr_a  in  ADDR_W  primary address
req_addr_b  in  ADDR_W  second address (swap only)
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  DATA_W  response data
busy  out  1  high whenever state != IDLE
rd_addr  in  ADDR_W  side read address
rd_data  out  DATA_W  mem[rd_addr], combinational

Behaviour:
- Clock is clk; reset is rst_n, synchronous and active-low; clk and rst_n as named above.
- States: CLEAR, IDLE, SWAP.
- Reset (rst_n low at an edge, from any state, mid-operation included): state <= CLEAR, clear counter <= 0, rsp_valid <= 0, rsp_data <= 0, swap temporaries <= 0. No array write during reset. Array contents are not reset directly.
- CLEAR: each edge with rst_n high writes the pattern value to mem[cnt] and increments cnt. The edge writing DEPTH-1 moves to IDLE. req_ready = 1 after exactly DEPTH edges with rst_n high.
  - Clear entered via reset: no rsp pulse.
  - Clear entered via command: rsp_valid = 1, rsp_data = 0 in the cycle after the last write.
- req_ready = (state == IDLE). A command is accepted on an edge with req_valid && req_ready. busy = !req_ready.
- READ: rsp_valid = 1, rsp_data = mem[addr_a] in the next cycle. State stays IDLE, so back-to-back reads run at one per cycle.
- WRITE: mem[addr_a] <= wdata at the accept edge. Next cycle: rsp_valid = 1, rsp_data = the previous contents of that entry.
- SWAP:
  - Accept edge latches tmp_a = mem[addr_a], tmp_b = mem[addr_b], both addresses; state <= SWAP.
  - SWAP edge writes mem[a] <= tmp_b and mem[b] <= tmp_a on the same edge, then state <= IDLE.
  - Next cycle: rsp_valid = 1, rsp_data = tmp_b (the new value at a).
  - a == b: contents unchanged; response still given.
  - Accept-to-response latency is 2 cycles.
- CLEAR op: state <= CLEAR, cnt <= 0.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_data holds its value between pulses.
- rd_data reflects writes from the following cycle onward. During CLEAR it shows partially cleared contents. A swap is never visible half-done.
- Unused addr_b and wdata are ignored. Commands presented while busy are not accepted and have no effect.

Test Plan:
1. Reset held 3 cycles, release; INIT_MODE=1, DEPTH=16 -> req_ready rises after 16 edges, no rsp pulse; rd_addr 0..15 reads 1..15,0.
2. Write 0x5A to addr 3, then read 3 -> write rsp_data = 4 (old value, INIT_MODE=1); read rsp_data = 0x5A one cycle after accept.
3. Swap a=14, b=15 on solved board -> req_ready low 1 cycle; rsp 2 cycles after accept with rsp_data = 0; then mem[14] = 0, mem[15] = 15.
4. Swap a=b=7 -> contents unchanged; rsp_data = 8.
5. Clear op, then assert rst_n low at clear step 5 -> rsp_valid never pulses; a fresh full DEPTH-cycle clear follows release.
6. Four back-to-back reads with req_valid held high -> four consecutive rsp pulses, each one cycle after its accept; req_valid asserted during SWAP is ignored.

Source files
------------

// File: rtl/board_ram.sv
// Board memory for the puzzle datapath: sequential clear engine, command port
// (read/write/swap/clear) and a combinational side read port for display/scan.
module board_ram #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned INIT_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_SWAP  = 2'd2;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_clr_rsp;
    logic [ADDR_W-1:0] r_addr_a;
    logic [ADDR_W-1:0] r_addr_b;
    logic [DATA_W-1:0] r_tmp_a;
    logic [DATA_W-1:0] r_tmp_b;

    logic              w_accept;
    logic              w_last;
    logic [ADDR_W-1:0] w_cnt_inc;
    logic [DATA_W-1:0] w_clr_val;

    assign req_ready = (r_state == S_IDLE);
    assign busy      = ~req_ready;
    assign w_accept  = req_valid && req_ready;
    assign w_last    = (r_cnt == ADDR_W'(DEPTH - 1));
    assign w_cnt_inc = r_cnt + ADDR_W'(1);
    assign rd_data   = r_mem[rd_addr];

    // Solved-board pattern wraps (i+1) so the last cell becomes the blank.
    always_comb begin
        w_clr_val = '0;
        if (INIT_MODE == 1) begin
            w_clr_val = DATA_W'(w_cnt_inc);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_accept && (req_op == OP_SWAP)) begin
                    w_state_nxt = S_SWAP;
                end else if (w_accept && (req_op == OP_CLEAR)) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_SWAP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // Array has no reset; writes are suppressed while rst_n is low.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            case (r_state)
                S_CLEAR: r_mem[r_cnt] <= w_clr_val;
                S_IDLE: begin
                    if (w_accept && (req_op == OP_WRITE)) begin
                        r_mem[req_addr_a] <= req_wdata;
                    end
                end
                S_SWAP: begin
                    r_mem[r_addr_a] <= r_tmp_b;
                    r_mem[r_addr_b] <= r_tmp_a;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_clr_rsp <= 1'b0;
            r_addr_a  <= '0;
            r_addr_b  <= '0;
            r_tmp_a   <= '0;
            r_tmp_b   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    r_cnt <= w_cnt_inc;
                    if (w_last) begin
                        r_clr_rsp <= 1'b0;
                        if (r_clr_rsp) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                        end
                    end
                end
                S_IDLE: begin
                    if (w_accept) begin
                        case (req_op)
                            OP_READ, OP_WRITE: begin
                                rsp_valid <= 1'b1;
                                rsp_data  <= r_mem[req_addr_a];
                            end
                            OP_SWAP: begin
                                r_addr_a <= req_addr_a;
                                r_addr_b <= req_addr_b;
                                r_tmp_a  <= r_mem[req_addr_a];
                                r_tmp_b  <= r_mem[req_addr_b];
                            end
                            default: begin
                                r_cnt     <= '0;
                                r_clr_rsp <= 1'b1;
                            end
                        endcase
                    end
                end
                S_SWAP: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= r_tmp_b;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_ram.sv
// Self-checking bench for board_ram (INIT_MODE=1, 16 x 8): vector table plus
// hand sequences for clear/reset abort and back-to-back traffic.
module tb_board_ram;

    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_SW = 2'b10;
    localparam logic [1:0] OP_CL = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [3:0] req_addr_a = '0;
    logic [3:0] req_addr_b = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data;

    board_ram #(.DATA_W(8), .ADDR_W(4), .INIT_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] wd;
        logic [7:0] exp_rsp;
        logic [3:0] chk_addr;
        logic [7:0] exp_rd;
    } vec_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   rsp_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every pulse must match the oldest expectation, in data and cycle.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            exp_t e;
            rsp_seen++;
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_data), 32'hDEAD);
            end else begin
                e = sb.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Present a command (called at #1 after a rising edge); returns #1 after its accept edge.
    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] wd, input logic [7:0] exp, input int lat,
                         input bit expect_rsp);
        int n;
        exp_t e;
        req_op = op; req_addr_a = a; req_addr_b = b; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) check("ready_timeout", 32'(n), 32'd0);
        if (expect_rsp) begin
            e.data = exp;
            e.cyc  = cyc + 1 + lat;
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check(name, 32'(n), 32'd16);
    endtask

    task automatic scan_solved(input string name);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            check(name, 32'(rd_data), 32'((i + 1) % 16));
        end
    endtask

    vec_t vecs[8];

    initial begin
        int   saved;
        vecs[0] = '{OP_WR, 4'd3,  4'd0,  8'h5A, 8'h04, 4'd3,  8'h5A};
        vecs[1] = '{OP_RD, 4'd3,  4'd0,  8'h00, 8'h5A, 4'd3,  8'h5A};
        vecs[2] = '{OP_SW, 4'd14, 4'd15, 8'h00, 8'h00, 4'd14, 8'h00};
        vecs[3] = '{OP_RD, 4'd15, 4'd0,  8'h00, 8'h0F, 4'd15, 8'h0F};
        vecs[4] = '{OP_SW, 4'd7,  4'd7,  8'h00, 8'h08, 4'd7,  8'h08};
        vecs[5] = '{OP_WR, 4'd0,  4'd0,  8'hFF, 8'h01, 4'd0,  8'hFF};
        vecs[6] = '{OP_SW, 4'd0,  4'd3,  8'h00, 8'h5A, 4'd3,  8'hFF};
        vecs[7] = '{OP_RD, 4'd0,  4'd0,  8'h00, 8'h5A, 4'd0,  8'h5A};

        // Reset held three cycles, then a full clear with no response.
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b1;
        wait_clear("init_clear_edges");
        check("init_no_rsp", 32'(rsp_seen), 32'd0);
        scan_solved("init_pattern");

        // Table of single commands on the solved board.
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wd, vecs[i].exp_rsp,
                  (vecs[i].op == OP_SW) ? 1 : 0, 1'b1);
            req_valid = 1'b0;
            if (vecs[i].op == OP_SW) begin
                check("swap_ready_low", 32'(req_ready), 32'd0);
                @(posedge clk); #1;
            end
            check("ready_after_cmd", 32'(req_ready), 32'd1);
            drain();
            rd_addr = vecs[i].chk_addr;
            #1;
            check("vec_rd_data", 32'(rd_data), 32'(vecs[i].exp_rd));
            @(posedge clk); #1;
            check("rsp_single_pulse", 32'(rsp_valid), 32'd0);
            check("rsp_data_hold", 32'(rsp_data), 32'(vecs[i].exp_rsp));
        end
        rd_addr = 4'd15;
        #1;
        check("swap_b_value", 32'(rd_data), 32'h0F);

        // Four back-to-back reads, then a command held during SWAP that must be ignored.
        issue(OP_RD, 4'd0, 4'd0, 8'h00, 8'h5A, 0, 1'b1);
        issue(OP_RD, 4'd1, 4'd0, 8'h00, 8'h02, 0, 1'b1);
        issue(OP_RD, 4'd2, 4'd0, 8'h00, 8'h03, 0, 1'b1);
        issue(OP_RD, 4'd3, 4'd0, 8'h00, 8'hFF, 0, 1'b1);
        issue(OP_SW, 4'd1, 4'd2, 8'h00, 8'h03, 1, 1'b1);
        req_op = OP_WR; req_addr_a = 4'd5; req_wdata = 8'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        drain();
        rd_addr = 4'd5; #1;
        check("busy_cmd_ignored", 32'(rd_data), 32'h06);
        rd_addr = 4'd1; #1;
        check("swap2_a", 32'(rd_data), 32'h03);
        rd_addr = 4'd2; #1;
        check("swap2_b", 32'(rd_data), 32'h02);

        // Full clear by command: response with zero data after the 16th write.
        issue(OP_CL, 4'd0, 4'd0, 8'h00, 8'h00, 16, 1'b1);
        req_valid = 1'b0;
        check("clear_busy", 32'(busy), 32'd1);
        drain();
        scan_solved("cmd_clear_pattern");

        // Dirty two cells, start a clear, then abort it with reset at step 5.
        issue(OP_WR, 4'd0, 4'd0, 8'hC3, 8'h01, 0, 1'b1);
        issue(OP_WR, 4'd9, 4'd0, 8'h3C, 8'h0A, 0, 1'b1);
        req_valid = 1'b0;
        drain();
        saved = rsp_seen;
        issue(OP_CL, 4'd0, 4'd0, 8'h00, 8'h00, 0, 1'b0);
        req_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rd_addr = 4'd0; #1;
        check("partial_clear_done", 32'(rd_data), 32'h01);
        rd_addr = 4'd9; #1;
        check("partial_clear_pending", 32'(rd_data), 32'h3C);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        wait_clear("abort_fresh_clear_edges");
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("abort_no_rsp", 32'(rsp_seen), 32'(saved));
        scan_solved("abort_pattern");

        check("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

endmodule
